// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and the downstream
// decode/execute stage. The master modport is the sequencer side.
interface fetch_sequencer_if #(
  parameter int PC_W = 4
);
  // imem: one-cycle imem_req pulse, then imem_rdata is sampled on the first cycle
  // imem_ack is high. Downstream: a transfer happens on a rising edge where
  // instr_valid & instr_ready; instr/pc stay stable while instr_valid is high and
  // exec_done (with optional redirect_valid) later reports completion.
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            exec_done;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] next_pc;

  modport master (
    output imem_req, imem_addr, instr, pc, instr_valid, next_pc,
    input  imem_ack, imem_rdata, instr_ready, exec_done, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, instr_valid, next_pc,
    output imem_ack, imem_rdata, instr_ready, exec_done, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch stage: owns the PC, fetches one instruction, issues it
// downstream and waits for execution to finish before fetching the next one.
module fetch_sequencer #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              JSHIFT   = 1,
  parameter int              CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fetch_sequencer_if.master    bus,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_ISSUE    = 3'd2,
    S_EXECUTE  = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       instr_q;
  logic [CNT_W-1:0]  retired_q;
  logic [PC_W-1:0]   next_pc;
  logic [PC_W-1:0]   jump_target;
  logic              done_now;

  // exec_done and redirect_valid only mean something while an instruction executes.
  assign done_now    = (state_q == S_EXECUTE) && bus.exec_done;
  assign jump_target = PC_W'({6'b0, instr_q[25:0]} << JSHIFT);

  always_comb begin
    next_pc = pc_q + PC_W'(4);
    if (done_now && bus.redirect_valid) begin
      next_pc = bus.redirect_pc;
    end else if (instr_q[31:26] == OP_J) begin
      next_pc = jump_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (enable) state_d = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (bus.imem_ack) begin
          state_d = (bus.imem_rdata[31:26] == OP_HALT) ? S_HALTED : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.instr_ready) state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (bus.exec_done) state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((state_q == S_WAIT_MEM) && bus.imem_ack) begin
        instr_q <= bus.imem_rdata;
      end
      if (done_now) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.imem_req    = (state_q == S_FETCH) && enable;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.next_pc     = next_pc;
  assign halted          = (state_q == S_HALTED);
  assign retired         = retired_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a scripted memory/downstream model with a
// scoreboard of expected {pc, instr} issues.
module tb_fetch_sequencer;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       halted;
  logic [7:0] retired;
  logic [2:0] state_dbg;

  fetch_sequencer_if #(.PC_W(4)) bus ();

  fetch_sequencer #(.PC_W(4), .RESET_PC(4'd0), .JSHIFT(1), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .halted    (halted),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [16];
  logic [35:0] exp_q [$];
  logic [3:0]  exp_pc;
  logic [7:0]  exp_ret;
  int          errors = 0;
  int          checks = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b0;
    enable = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.exec_done = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_pc = 4'd0;
    exp_ret = 8'd0;
  endtask

  task automatic wait_req(output bit ok);
    #1;
    ok = bus.imem_req;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = bus.imem_req;
    end
  endtask

  // One full instruction: fetch, memory response, issue, accept, execute.
  task automatic exec_one(input int lat, input int rdy_wait, input int nodone,
                          input bit redir, input logic [3:0] rpc,
                          input bit drop_en, input bit rst_mid);
    bit          ok;
    bit          bad;
    logic [31:0] w;
    logic [31:0] jt;
    logic [35:0] item;
    logic [3:0]  new_pc;
    enable = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_req: no imem_req within 20 cycles, expected fetch of pc %0d", exp_pc);
      return;
    end
    checks++;
    if (bus.imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL imem_addr: got %0d expected %0d", bus.imem_addr, exp_pc);
    end
    w = imem[exp_pc];
    exp_q.push_back({exp_pc, w});
    repeat (lat) begin
      @(posedge clk);
      #1;
      if (drop_en) enable = 1'b0;
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.instr_valid;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue: instr_valid not seen within 20 cycles at pc %0d", exp_pc);
    end
    if (rdy_wait > 0) begin
      bad = 1'b0;
      bus.exec_done = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 4'hF;
      for (int i = 0; i < rdy_wait; i++) begin
        @(negedge clk);
        if (bus.instr_valid !== 1'b1 || bus.pc !== exp_pc || bus.instr !== w || bus.imem_req !== 1'b0)
          bad = 1'b1;
      end
      bus.exec_done = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL backpressure: valid=%b pc=%0d instr=%h req=%b, required valid=1 pc=%0d instr=%h req=0",
                 bus.instr_valid, bus.pc, bus.instr, bus.imem_req, exp_pc, w);
      end
    end
    bus.instr_ready = 1'b1;
    #1;
    item = exp_q.pop_front();
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== item) begin
      errors++;
      $display("FAIL transfer: valid=%b pc=%0d instr=%h, expected pc=%0d instr=%h",
               bus.instr_valid, bus.pc, bus.instr, item[35:32], item[31:0]);
    end
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || state_dbg !== ST_EXEC) begin
      errors++;
      $display("FAIL accept: valid=%b state=%0d, expected valid=0 state=%0d", bus.instr_valid, state_dbg, ST_EXEC);
    end
    if (rst_mid) begin
      #2;
      rst = 1'b0;
      #1;
      exp_pc = 4'd0;
      exp_ret = 8'd0;
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.pc !== exp_pc || state_dbg !== ST_FETCH) begin
        errors++;
        $display("FAIL async_reset: valid=%b pc=%0d state=%0d, expected 0 0 0", bus.instr_valid, bus.pc, state_dbg);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL async_reset_retired: got %0d expected 0", retired);
      end
      return;
    end
    if (nodone > 0) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 4'hF;
      repeat (nodone) @(posedge clk);
      #1;
      checks++;
      if (bus.pc !== exp_pc || state_dbg !== ST_EXEC) begin
        errors++;
        $display("FAIL redirect_no_done: pc=%0d state=%0d, expected pc=%0d state=%0d", bus.pc, state_dbg, exp_pc, ST_EXEC);
      end
    end
    if (redir) begin
      new_pc = rpc;
    end else if (w[31:26] == 6'b000010) begin
      jt = {6'b0, w[25:0]} << 1;
      new_pc = jt[3:0];
    end else begin
      new_pc = exp_pc + 4'd4;
    end
    bus.exec_done = 1'b1;
    bus.redirect_valid = redir;
    bus.redirect_pc = rpc;
    #1;
    checks++;
    if (bus.next_pc !== new_pc) begin
      errors++;
      $display("FAIL next_pc: got %0d expected %0d", bus.next_pc, new_pc);
    end
    @(posedge clk);
    #1;
    bus.exec_done = 1'b0;
    bus.redirect_valid = 1'b0;
    exp_pc = new_pc;
    exp_ret = exp_ret + 8'd1;
    @(negedge clk);
    checks++;
    if (bus.pc !== exp_pc) begin
      errors++;
      $display("FAIL pc_update: got %0d expected %0d", bus.pc, exp_pc);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (state_dbg !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_FETCH); end
    checks++;
    if (bus.pc !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", bus.pc); end
    checks++;
    if (bus.instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
    checks++;
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++;
    if (retired !== 8'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
  endtask

  task automatic test_jump_sequential();
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b0);   // pc 0: j -> 8
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b0);   // pc 8 -> 12
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b0);   // pc 12 -> 0 (wrap)
  endtask

  task automatic test_backpressure();
    exec_one(1, 5, 0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_redirect();
    exec_one(1, 0, 0, 1'b1, 4'd4, 1'b0, 1'b0);   // pc 8 redirected to 4
    exec_one(1, 0, 2, 1'b1, 4'd2, 1'b0, 1'b0);   // pc 4: redirect without done first, then to 2
  endtask

  task automatic test_wrap_enable();
    bit bad;
    enable = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || state_dbg !== ST_FETCH) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL enable_low: req=%b state=%0d, expected req=0 state=%0d", bus.imem_req, state_dbg, ST_FETCH);
    end
    exec_one(2, 0, 0, 1'b1, 4'd12, 1'b1, 1'b0);  // enable dropped in WAIT_MEM
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b0);   // pc 12 -> 0
  endtask

  task automatic test_async_reset();
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b0);   // pc 0 -> 8
    exec_one(1, 0, 0, 1'b0, 4'd0, 1'b0, 1'b1);   // reset while executing pc 8
    enable = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hFC000000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_FETCH || bus.instr !== 32'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL stale_ack: state=%0d instr=%h halted=%b, expected state=%0d instr=0 halted=0",
               state_dbg, bus.instr, halted, ST_FETCH);
    end
  endtask

  task automatic test_halt();
    bit ok;
    bit bad;
    imem[0] = 32'hFC000000;
    enable = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || bus.imem_addr !== 4'd0) begin
      errors++;
      $display("FAIL halt_fetch: req_seen=%b addr=%0d, expected 1 and 0", ok, bus.imem_addr);
    end
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = imem[0];
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.instr_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL halt_valid: instr_valid asserted, expected 0"); end
    checks++;
    if (halted !== 1'b1 || state_dbg !== ST_HALT) begin
      errors++;
      $display("FAIL halt_state: halted=%b state=%0d, expected 1 and %0d", halted, state_dbg, ST_HALT);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h08000004;
    bus.exec_done = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 4'd5;
    bus.instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.exec_done = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr !== 32'hFC000000 || bus.pc !== 4'd0 || halted !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: instr=%h pc=%0d halted=%b req=%b, expected FC000000 0 1 0",
               bus.instr, bus.pc, halted, bus.imem_req);
    end
    checks++;
    if (retired !== 8'd0) begin errors++; $display("FAIL halt_retired: got %0d expected 0", retired); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'd0;
    imem[0]  = 32'h08000004;
    imem[4]  = 32'h02118020;
    imem[8]  = 32'h02118020;
    imem[12] = 32'h02328020;
    test_reset();
    test_jump_sequential();
    test_backpressure();
    test_redirect();
    test_wrap_enable();
    test_async_reset();
    test_halt();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected issues never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
